decode_stage: RTL and testbench

- Second pipeline stage of the OTTER RV32I core. Sits directly downstream of the fetch stage.
- Consumes the fetch-register outputs (IR, PC, PC+4) and decodes the instruction.
- Reads the 32x32 register file and generates the immediate and control signals.
- Detects load-use hazards (driving the fetch-stage stall) and loads the decode/execute pipeline register every cycle, unless a bubble is forced.

---
 rtl/otter_pkg.sv | 66 ++++++
 rtl/decode_stage_if.sv | 56 +++++
 rtl/reg_file.sv | 26 ++
 rtl/decode_stage.sv | 173 +++++++++++++++++
 tb/tb_decode_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER RV32I types: opcodes, ALU codes, mux selects and the
// decode/execute pipeline register layout used by decode and execute.
package otter_pkg;

    localparam int OTTER_XLEN = 32;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_OP     = 7'b0110011
    } opcode_t;

    // Encoding is {funct7[5], funct3}; LUI_COPY passes operand A through.
    typedef enum logic [3:0] {
        ALU_ADD      = 4'b0000,
        ALU_SLL      = 4'b0001,
        ALU_SLT      = 4'b0010,
        ALU_SLTU     = 4'b0011,
        ALU_XOR      = 4'b0100,
        ALU_SRL      = 4'b0101,
        ALU_OR       = 4'b0110,
        ALU_AND      = 4'b0111,
        ALU_SUB      = 4'b1000,
        ALU_LUI_COPY = 4'b1001,
        ALU_SRA      = 4'b1101
    } alu_fun_t;

    localparam logic [1:0] ALU_SRCB_RS2 = 2'd0;
    localparam logic [1:0] ALU_SRCB_IMM = 2'd1;
    localparam logic [1:0] ALU_SRCB_PC  = 2'd2;

    localparam logic [1:0] RF_WR_SEL_ALU = 2'd0;
    localparam logic [1:0] RF_WR_SEL_MEM = 2'd1;
    localparam logic [1:0] RF_WR_SEL_PC4 = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic [OTTER_XLEN-1:0] pc;
        logic [OTTER_XLEN-1:0] pc_4;
        logic [OTTER_XLEN-1:0] rs1_data;
        logic [OTTER_XLEN-1:0] rs2_data;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [OTTER_XLEN-1:0] imm;
        alu_fun_t              alu_fun;
        logic                  alu_srca;
        logic [1:0]            alu_srcb;
        logic [1:0]            rf_wr_sel;
        logic                  reg_write;
        logic                  mem_write;
        logic                  mem_read;
        logic [2:0]            funct3;
        logic                  branch;
        logic                  jal;
        logic                  jalr;
        logic                  illegal;
    } dec_ex_reg_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode, hazard, writeback and decode/execute signal bundle.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            FETCH_VALID;
    logic [XLEN-1:0] FETCH_IR;
    logic [XLEN-1:0] FETCH_PC;
    logic [XLEN-1:0] FETCH_PC_4;
    logic            FLUSH;
    logic            EX_MEM_READ;
    logic [4:0]      EX_RD;
    logic            WB_WE;
    logic [4:0]      WB_RD;
    logic [XLEN-1:0] WB_DATA;

    logic            STALL;
    logic            DEC_VALID;
    logic [XLEN-1:0] DEC_PC;
    logic [XLEN-1:0] DEC_PC_4;
    logic [XLEN-1:0] DEC_RS1_DATA;
    logic [XLEN-1:0] DEC_RS2_DATA;
    logic [4:0]      DEC_RS1;
    logic [4:0]      DEC_RS2;
    logic [4:0]      DEC_RD;
    logic [XLEN-1:0] DEC_IMM;
    logic [3:0]      DEC_ALU_FUN;
    logic            DEC_ALU_SRCA;
    logic [1:0]      DEC_ALU_SRCB;
    logic [1:0]      DEC_RF_WR_SEL;
    logic            DEC_REG_WRITE;
    logic            DEC_MEM_WRITE;
    logic            DEC_MEM_READ;
    logic [2:0]      DEC_FUNCT3;
    logic            DEC_BRANCH;
    logic            DEC_JAL;
    logic            DEC_JALR;
    logic            DEC_ILLEGAL;

    modport master (
        output FETCH_VALID, FETCH_IR, FETCH_PC, FETCH_PC_4, FLUSH,
               EX_MEM_READ, EX_RD, WB_WE, WB_RD, WB_DATA,
        input  STALL, DEC_VALID, DEC_PC, DEC_PC_4, DEC_RS1_DATA, DEC_RS2_DATA,
               DEC_RS1, DEC_RS2, DEC_RD, DEC_IMM, DEC_ALU_FUN, DEC_ALU_SRCA,
               DEC_ALU_SRCB, DEC_RF_WR_SEL, DEC_REG_WRITE, DEC_MEM_WRITE,
               DEC_MEM_READ, DEC_FUNCT3, DEC_BRANCH, DEC_JAL, DEC_JALR, DEC_ILLEGAL
    );

    modport slave (
        input  FETCH_VALID, FETCH_IR, FETCH_PC, FETCH_PC_4, FLUSH,
               EX_MEM_READ, EX_RD, WB_WE, WB_RD, WB_DATA,
        output STALL, DEC_VALID, DEC_PC, DEC_PC_4, DEC_RS1_DATA, DEC_RS2_DATA,
               DEC_RS1, DEC_RS2, DEC_RD, DEC_IMM, DEC_ALU_FUN, DEC_ALU_SRCA,
               DEC_ALU_SRCB, DEC_RF_WR_SEL, DEC_REG_WRITE, DEC_MEM_WRITE,
               DEC_MEM_READ, DEC_FUNCT3, DEC_BRANCH, DEC_JAL, DEC_JALR, DEC_ILLEGAL
    );
endinterface

// File: rtl/reg_file.sv
// 2-read/1-write register file; x0 reads zero, same-cycle writes bypass to reads.
module reg_file #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                        CLOCK,
    input  logic [$clog2(NUM_REGS)-1:0] raddr_i [2],
    output logic [XLEN-1:0]             rdata_o [2],
    input  logic                        we_i,
    input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
    input  logic [XLEN-1:0]             wdata_i
);
    logic [XLEN-1:0] mem_q [NUM_REGS];

    always_ff @(posedge CLOCK) begin
        if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        assign rdata_o[gi] = (raddr_i[gi] == '0)                   ? '0      :
                             (we_i && (waddr_i == raddr_i[gi]))    ? wdata_i :
                                                                     mem_q[raddr_i[gi]];
    end
endmodule

// File: rtl/decode_stage.sv
// OTTER decode stage: decodes the fetched instruction, reads operands,
// detects load-use hazards and loads the decode/execute pipeline register.
module decode_stage
    import otter_pkg::*;
#(
    parameter int XLEN     = OTTER_XLEN,
    parameter int NUM_REGS = 32
) (
    input  logic          CLOCK,
    input  logic          RESET,
    decode_stage_if.slave bus
);
    logic [31:0]     ir;
    opcode_t         opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [4:0]      rf_raddr [2];
    logic [XLEN-1:0] rf_rdata [2];
    logic            rs1_used, rs2_used, hazard;
    dec_ex_reg_t     decoded, dec_d, dec_q;

    assign ir      = bus.FETCH_IR;
    assign opcode  = opcode_t'(ir[6:0]);
    assign funct3  = ir[14:12];
    assign rs1_idx = ir[19:15];
    assign rs2_idx = ir[24:20];
    assign rd_idx  = ir[11:7];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign rf_raddr[0] = rs1_idx;
    assign rf_raddr[1] = rs2_idx;

    reg_file #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .CLOCK   (CLOCK),
        .raddr_i (rf_raddr),
        .rdata_o (rf_rdata),
        .we_i    (bus.WB_WE),
        .waddr_i (bus.WB_RD),
        .wdata_i (bus.WB_DATA)
    );

    always_comb begin
        decoded          = '0;
        rs1_used         = 1'b0;
        rs2_used         = 1'b0;
        decoded.valid    = 1'b1;
        decoded.pc       = bus.FETCH_PC;
        decoded.pc_4     = bus.FETCH_PC_4;
        decoded.rs1_data = rf_rdata[0];
        decoded.rs2_data = rf_rdata[1];
        decoded.rs1      = rs1_idx;
        decoded.rs2      = rs2_idx;
        decoded.rd       = rd_idx;
        decoded.funct3   = funct3;
        case (opcode)
            OP_LUI: begin
                decoded.imm       = imm_u;
                decoded.alu_fun   = ALU_LUI_COPY;
                decoded.alu_srca  = 1'b1;
                decoded.alu_srcb  = ALU_SRCB_IMM;
                decoded.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                decoded.imm       = imm_u;
                decoded.alu_srca  = 1'b1;
                decoded.alu_srcb  = ALU_SRCB_PC;
                decoded.reg_write = 1'b1;
            end
            OP_JAL: begin
                decoded.imm       = imm_j;
                decoded.rf_wr_sel = RF_WR_SEL_PC4;
                decoded.reg_write = 1'b1;
                decoded.jal       = 1'b1;
            end
            OP_JALR: begin
                rs1_used          = 1'b1;
                decoded.imm       = imm_i;
                decoded.alu_srcb  = ALU_SRCB_IMM;
                decoded.rf_wr_sel = RF_WR_SEL_PC4;
                decoded.reg_write = 1'b1;
                decoded.jalr      = 1'b1;
            end
            OP_BRANCH: begin
                rs1_used          = 1'b1;
                rs2_used          = 1'b1;
                decoded.imm       = imm_b;
                decoded.branch    = 1'b1;
            end
            OP_LOAD: begin
                rs1_used          = 1'b1;
                decoded.imm       = imm_i;
                decoded.alu_srcb  = ALU_SRCB_IMM;
                decoded.rf_wr_sel = RF_WR_SEL_MEM;
                decoded.reg_write = 1'b1;
                decoded.mem_read  = 1'b1;
            end
            OP_STORE: begin
                rs1_used          = 1'b1;
                rs2_used          = 1'b1;
                decoded.imm       = imm_s;
                decoded.alu_srcb  = ALU_SRCB_IMM;
                decoded.mem_write = 1'b1;
            end
            // funct7[5] only selects SRAI among the immediate ops.
            OP_IMM: begin
                rs1_used          = 1'b1;
                decoded.imm       = imm_i;
                decoded.alu_fun   = alu_fun_t'({(funct3 == 3'b101) & ir[30], funct3});
                decoded.alu_srcb  = ALU_SRCB_IMM;
                decoded.reg_write = 1'b1;
            end
            OP_OP: begin
                rs1_used          = 1'b1;
                rs2_used          = 1'b1;
                decoded.alu_fun   = alu_fun_t'({((funct3 == 3'b000) || (funct3 == 3'b101)) & ir[30],
                                                funct3});
                decoded.reg_write = 1'b1;
            end
            default: begin
                decoded.illegal   = 1'b1;
            end
        endcase
    end

    assign hazard = bus.EX_MEM_READ && (bus.EX_RD != 5'd0) && bus.FETCH_VALID &&
                    ((rs1_used && (rs1_idx == bus.EX_RD)) ||
                     (rs2_used && (rs2_idx == bus.EX_RD)));

    // A flush kills the instruction anyway, so holding fetch would be wasted.
    assign bus.STALL = hazard && !bus.FLUSH && !RESET;

    // A bubble is the all-zero register, identical to the reset value.
    assign dec_d = (bus.FLUSH || hazard || !bus.FETCH_VALID) ? '0 : decoded;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign bus.DEC_VALID     = dec_q.valid;
    assign bus.DEC_PC        = dec_q.pc;
    assign bus.DEC_PC_4      = dec_q.pc_4;
    assign bus.DEC_RS1_DATA  = dec_q.rs1_data;
    assign bus.DEC_RS2_DATA  = dec_q.rs2_data;
    assign bus.DEC_RS1       = dec_q.rs1;
    assign bus.DEC_RS2       = dec_q.rs2;
    assign bus.DEC_RD        = dec_q.rd;
    assign bus.DEC_IMM       = dec_q.imm;
    assign bus.DEC_ALU_FUN   = dec_q.alu_fun;
    assign bus.DEC_ALU_SRCA  = dec_q.alu_srca;
    assign bus.DEC_ALU_SRCB  = dec_q.alu_srcb;
    assign bus.DEC_RF_WR_SEL = dec_q.rf_wr_sel;
    assign bus.DEC_REG_WRITE = dec_q.reg_write;
    assign bus.DEC_MEM_WRITE = dec_q.mem_write;
    assign bus.DEC_MEM_READ  = dec_q.mem_read;
    assign bus.DEC_FUNCT3    = dec_q.funct3;
    assign bus.DEC_BRANCH    = dec_q.branch;
    assign bus.DEC_JAL       = dec_q.jal;
    assign bus.DEC_JALR      = dec_q.jalr;
    assign bus.DEC_ILLEGAL   = dec_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized check of decode_stage against an instruction-level
// reference model that tracks the architectural register file.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc, pc4, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  fun;
        logic        srca;
        logic [1:0]  srcb, wsel;
        logic        rw, mw, mr;
        logic [2:0]  f3;
        logic        br, jal, jalr, ill;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_rf [32];
    exp_t        exp_q;
    logic        exp_stall;
    logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.WB_WE && bus.WB_RD == a) return bus.WB_DATA;
        return model_rf[a];
    endfunction

    // Instruction-level view: classify opcode, derive operand usage and
    // immediates arithmetically, then apply reset/flush/stall/valid priority.
    task automatic predict(output logic stall, output exp_t e);
        logic [31:0]        ir, sh;
        logic signed [31:0] s;
        logic [6:0]         op;
        logic [2:0]         f3;
        logic lui, auipc, jal, jalr, br, ld, st, opi, opr, legal, use1, use2, haz;
        ir = bus.FETCH_IR; s = ir; op = ir[6:0]; f3 = ir[14:12];
        lui = (op == 7'h37); auipc = (op == 7'h17); jal = (op == 7'h6F);
        jalr = (op == 7'h67); br = (op == 7'h63); ld = (op == 7'h03);
        st = (op == 7'h23); opi = (op == 7'h13); opr = (op == 7'h33);
        legal = lui | auipc | jal | jalr | br | ld | st | opi | opr;
        use1 = legal && !(lui || auipc || jal);
        use2 = br || st || opr;
        haz = bus.EX_MEM_READ && (bus.EX_RD != 5'd0) && bus.FETCH_VALID &&
              ((use1 && ir[19:15] == bus.EX_RD) || (use2 && ir[24:20] == bus.EX_RD));
        stall = haz && !bus.FLUSH && !rst;
        e = '{default: 0};
        if (!(rst || bus.FLUSH || haz || !bus.FETCH_VALID)) begin
            e.valid = 1'b1;
            e.pc = bus.FETCH_PC; e.pc4 = bus.FETCH_PC_4;
            e.d1 = rf_read(ir[19:15]); e.d2 = rf_read(ir[24:20]);
            e.rs1 = ir[19:15]; e.rs2 = ir[24:20]; e.rd = ir[11:7]; e.f3 = f3;
            if (lui || auipc) e.imm = ir & 32'hFFFFF000;
            else if (jal) begin
                sh = s >>> 11;
                e.imm = (sh & 32'hFFF00000) | (32'(ir[19:12]) << 12) |
                        (32'(ir[20]) << 11) | (32'(ir[30:21]) << 1);
            end else if (br) begin
                sh = s >>> 19;
                e.imm = (sh & 32'hFFFFF000) | (32'(ir[7]) << 11) |
                        (32'(ir[30:25]) << 5) | (32'(ir[11:8]) << 1);
            end else if (st) begin
                sh = s >>> 20;
                e.imm = (sh & 32'hFFFFFFE0) | 32'(ir[11:7]);
            end else if (jalr || ld || opi) begin
                sh = s >>> 20;
                e.imm = sh;
            end
            if (lui) e.fun = 4'd9;
            else if (opi) e.fun = {(f3 == 3'd5) & ir[30], f3};
            else if (opr) e.fun = {(f3 == 3'd0 || f3 == 3'd5) & ir[30], f3};
            e.srca = lui || auipc;
            e.srcb = auipc ? 2'd2 : (lui || jalr || ld || st || opi) ? 2'd1 : 2'd0;
            e.wsel = ld ? 2'd1 : (jal || jalr) ? 2'd2 : 2'd0;
            e.rw = lui || auipc || jal || jalr || ld || opi || opr;
            e.mw = st; e.mr = ld; e.br = br; e.jal = jal; e.jalr = jalr;
            e.ill = !legal;
        end
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.FETCH_VALID = 1'b0; bus.FETCH_IR = 32'h0; bus.FLUSH = 1'b0;
        bus.FETCH_PC = $urandom & 32'hFFFFFFFC;
        bus.FETCH_PC_4 = bus.FETCH_PC + 32'd4;
        bus.EX_MEM_READ = 1'b0; bus.EX_RD = 5'd0;
        bus.WB_WE = 1'b0; bus.WB_RD = 5'd0; bus.WB_DATA = 32'h0;
    endtask

    task automatic check_outputs();
        chk("DEC_VALID", 32'(bus.DEC_VALID), 32'(exp_q.valid));
        chk("DEC_PC", bus.DEC_PC, exp_q.pc);
        chk("DEC_PC_4", bus.DEC_PC_4, exp_q.pc4);
        chk("DEC_RS1_DATA", bus.DEC_RS1_DATA, exp_q.d1);
        chk("DEC_RS2_DATA", bus.DEC_RS2_DATA, exp_q.d2);
        chk("DEC_RS1", 32'(bus.DEC_RS1), 32'(exp_q.rs1));
        chk("DEC_RS2", 32'(bus.DEC_RS2), 32'(exp_q.rs2));
        chk("DEC_RD", 32'(bus.DEC_RD), 32'(exp_q.rd));
        chk("DEC_IMM", bus.DEC_IMM, exp_q.imm);
        chk("DEC_ALU_FUN", 32'(bus.DEC_ALU_FUN), 32'(exp_q.fun));
        chk("DEC_ALU_SRCA", 32'(bus.DEC_ALU_SRCA), 32'(exp_q.srca));
        chk("DEC_ALU_SRCB", 32'(bus.DEC_ALU_SRCB), 32'(exp_q.srcb));
        chk("DEC_RF_WR_SEL", 32'(bus.DEC_RF_WR_SEL), 32'(exp_q.wsel));
        chk("DEC_REG_WRITE", 32'(bus.DEC_REG_WRITE), 32'(exp_q.rw));
        chk("DEC_MEM_WRITE", 32'(bus.DEC_MEM_WRITE), 32'(exp_q.mw));
        chk("DEC_MEM_READ", 32'(bus.DEC_MEM_READ), 32'(exp_q.mr));
        chk("DEC_FUNCT3", 32'(bus.DEC_FUNCT3), 32'(exp_q.f3));
        chk("DEC_BRANCH", 32'(bus.DEC_BRANCH), 32'(exp_q.br));
        chk("DEC_JAL", 32'(bus.DEC_JAL), 32'(exp_q.jal));
        chk("DEC_JALR", 32'(bus.DEC_JALR), 32'(exp_q.jalr));
        chk("DEC_ILLEGAL", 32'(bus.DEC_ILLEGAL), 32'(exp_q.ill));
    endtask

    // Inputs are already driven; check STALL, clock once, check DEC_*.
    task automatic cycle(input string name);
        exp_t nxt;
        #1;
        predict(exp_stall, nxt);
        chk("STALL", 32'(bus.STALL), 32'(exp_stall));
        @(posedge clk);
        if (bus.WB_WE && bus.WB_RD != 5'd0) model_rf[bus.WB_RD] = bus.WB_DATA;
        exp_q = nxt;
        #1;
        check_outputs();
        $display("txn %-10s ir=%h valid=%0d stall=%0d -> dec_valid=%0d imm=%h", name,
                 bus.FETCH_IR, bus.FETCH_VALID, exp_stall, bus.DEC_VALID, bus.DEC_IMM);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;

        idle(); rst = 1'b1; cycle("reset");
        idle(); rst = 1'b1; bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'h00500093; cycle("reset");

        for (int i = 1; i < 32; i++) begin
            idle(); bus.WB_WE = 1'b1; bus.WB_RD = 5'(i); bus.WB_DATA = $urandom;
            cycle("rf_init");
        end

        idle(); bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'h00500093; cycle("addi");
        chk("ADDI_RD", 32'(bus.DEC_RD), 32'd1);
        chk("ADDI_IMM", bus.DEC_IMM, 32'd5);
        chk("ADDI_SRCB", 32'(bus.DEC_ALU_SRCB), 32'd1);
        chk("ADDI_RW", 32'(bus.DEC_REG_WRITE), 32'd1);
        chk("ADDI_VALID", 32'(bus.DEC_VALID), 32'd1);

        idle(); bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'hFE208CE3; cycle("beq");
        chk("BEQ_IMM", bus.DEC_IMM, 32'hFFFFFFF8);
        chk("BEQ_BRANCH", 32'(bus.DEC_BRANCH), 32'd1);
        chk("BEQ_FUNCT3", 32'(bus.DEC_FUNCT3), 32'd0);
        chk("BEQ_RS1", 32'(bus.DEC_RS1), 32'd1);
        chk("BEQ_RS2", 32'(bus.DEC_RS2), 32'd2);
        chk("BEQ_RW", 32'(bus.DEC_REG_WRITE), 32'd0);

        idle(); bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'h00028333;
        bus.WB_WE = 1'b1; bus.WB_RD = 5'd5; bus.WB_DATA = 32'hDEADBEEF; cycle("add_wt");
        chk("WT_RS1_DATA", bus.DEC_RS1_DATA, 32'hDEADBEEF);

        idle(); bus.WB_WE = 1'b1; bus.WB_RD = 5'd0; bus.WB_DATA = 32'h1234; cycle("wr_x0");
        idle(); bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'h00500093; cycle("rd_x0");
        chk("X0_RS1_DATA", bus.DEC_RS1_DATA, 32'd0);

        idle(); bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'h00218233;
        bus.EX_MEM_READ = 1'b1; bus.EX_RD = 5'd3; cycle("hazard");
        chk("HAZ_STALL", 32'(bus.STALL), 32'd1);
        chk("HAZ_VALID", 32'(bus.DEC_VALID), 32'd0);
        chk("HAZ_RW", 32'(bus.DEC_REG_WRITE), 32'd0);
        bus.EX_MEM_READ = 1'b0; cycle("resume");
        chk("RESUME_STALL", 32'(bus.STALL), 32'd0);
        chk("RESUME_VALID", 32'(bus.DEC_VALID), 32'd1);
        chk("RESUME_RD", 32'(bus.DEC_RD), 32'd4);

        idle(); bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'h00218233;
        bus.EX_MEM_READ = 1'b1; bus.EX_RD = 5'd3; bus.FLUSH = 1'b1; cycle("flush");
        chk("FLUSH_STALL", 32'(bus.STALL), 32'd0);
        chk("FLUSH_VALID", 32'(bus.DEC_VALID), 32'd0);

        idle(); bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'h00308393;
        bus.EX_MEM_READ = 1'b1; bus.EX_RD = 5'd3; cycle("addi_nohaz");
        chk("NOHAZ_VALID", 32'(bus.DEC_VALID), 32'd1);

        idle(); bus.FETCH_IR = 32'h00218233; bus.EX_MEM_READ = 1'b1; bus.EX_RD = 5'd3;
        cycle("invalid");
        chk("INV_STALL", 32'(bus.STALL), 32'd0);

        idle(); bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'h0000007F; cycle("illegal");
        chk("ILL_FLAG", 32'(bus.DEC_ILLEGAL), 32'd1);
        chk("ILL_ENABLES", {29'd0, bus.DEC_REG_WRITE, bus.DEC_MEM_WRITE, bus.DEC_MEM_READ}, 32'd0);

        idle(); bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'h0020A423; cycle("sw");
        chk("SW_MW", 32'(bus.DEC_MEM_WRITE), 32'd1);
        chk("SW_IMM", bus.DEC_IMM, 32'd8);
        idle(); rst = 1'b1; bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'h00500093; cycle("mid_reset");
        chk("RST_MW", 32'(bus.DEC_MEM_WRITE), 32'd0);
        chk("RST_PC", bus.DEC_PC, 32'd0);
        idle(); bus.FETCH_VALID = 1'b1; bus.FETCH_IR = 32'h00500093; cycle("post_reset");
        chk("POST_VALID", 32'(bus.DEC_VALID), 32'd1);

        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 49) == 0);
            bus.FETCH_VALID = ($urandom_range(0, 9) != 0);
            bus.FETCH_IR = $urandom;
            k = int'($urandom_range(0, 9));
            if (k < 9) bus.FETCH_IR[6:0] = ops[k];
            bus.FLUSH = ($urandom_range(0, 9) == 0);
            bus.EX_MEM_READ = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 2))
                0: bus.EX_RD = bus.FETCH_IR[19:15];
                1: bus.EX_RD = bus.FETCH_IR[24:20];
                default: bus.EX_RD = 5'($urandom);
            endcase
            bus.WB_WE = ($urandom_range(0, 1) == 0);
            bus.WB_RD = ($urandom_range(0, 3) == 0) ? bus.FETCH_IR[19:15] : 5'($urandom);
            bus.WB_DATA = $urandom;
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
